// File: rtl/mdu_busy_unit.sv
// rtl/mdu_busy_unit.sv - E-stage multiply/divide unit owning HI/LO with busy/pending hazard output
// Results are computed when the op is accepted and held until the busy period expires.
module mdu_busy_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        pending,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        dz_q, dz_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_arith;
  logic [63:0] res_calc;
  logic        dz_calc;
  logic [63:0] ext_a, ext_b;
  logic [63:0] prod_s, prod_u;
  logic [31:0] mag_a, mag_b;
  logic [31:0] q_mag, r_mag;
  logic [31:0] q_s, r_s;
  logic [31:0] q_u, r_u;

  assign is_arith = (op == OP_MULT) || (op == OP_MULTU) ||
                    (op == OP_DIV)  || (op == OP_DIVU);

  assign busy    = (state_q == S_BUSY);
  assign pending = (start && is_arith) || busy;
  assign hi      = hi_q;
  assign lo      = lo_q;

  // Low 64 bits of the sign-extended product equal the signed 32x32 product.
  assign ext_a  = {{32{rs_val[31]}}, rs_val};
  assign ext_b  = {{32{rt_val[31]}}, rt_val};
  assign prod_s = ext_a * ext_b;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide on magnitudes: quotient truncates toward zero, remainder
  // takes the dividend's sign. 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign mag_a = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign mag_b = rt_val[31] ? (32'd0 - rt_val) : rt_val;

  always_comb begin
    q_mag = 32'd0;
    r_mag = 32'd0;
    q_u   = 32'd0;
    r_u   = 32'd0;
    if (rt_val != 32'd0) begin
      q_mag = mag_a / mag_b;
      r_mag = mag_a % mag_b;
      q_u   = rs_val / rt_val;
      r_u   = rs_val % rt_val;
    end
  end

  assign q_s = (rs_val[31] ^ rt_val[31]) ? (32'd0 - q_mag) : q_mag;
  assign r_s = rs_val[31] ? (32'd0 - r_mag) : r_mag;

  always_comb begin
    res_calc = 64'd0;
    dz_calc  = 1'b0;
    case (op)
      OP_MULT:  res_calc = prod_s;
      OP_MULTU: res_calc = prod_u;
      OP_DIV: begin
        dz_calc  = (rt_val == 32'd0);
        res_calc = {r_s, q_s};
      end
      OP_DIVU: begin
        dz_calc  = (rt_val == 32'd0);
        res_calc = {r_u, q_u};
      end
      default: res_calc = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      dz_q    <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Requests arriving while busy fall through untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start && is_arith) begin
          state_d = S_BUSY;
          cnt_d   = ((op == OP_MULT) || (op == OP_MULTU)) ? MULT_N : DIV_N;
          res_d   = res_calc;
          dz_d    = dz_calc;
        end else if (start && (op == OP_MTHI)) begin
          hi_d = rs_val;
        end else if (start && (op == OP_MTLO)) begin
          lo_d = rs_val;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          if (!dz_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_busy_unit.sv
// tb/tb_mdu_busy_unit.sv - directed vector bench for mdu_busy_unit
module tb_mdu_busy_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        pending;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  mdu_busy_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val),
    .busy(busy), .pending(pending), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          cyc;
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Caller must be at a falling edge; returns at the falling edge where busy is low.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int ecyc,
                        input string name);
    logic [31:0] ph, pl;
    int          cyc;
    logic        early;
    ph = hi;
    pl = lo;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    #1;
    chk({name, " pending"}, {63'd0, pending}, {63'd0, (o >= 3'd1 && o <= 3'd4)});
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    cyc   = 0;
    early = 1'b0;
    while (busy && cyc < 40) begin
      cyc++;
      if (hi !== ph || lo !== pl) early = 1'b1;
      @(negedge clk);
    end
    chk({name, " busy_cycles"}, 64'(cyc), 64'(ecyc));
    chk({name, " early_update"}, {63'd0, early}, 64'd0);
    chk({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    chk({name, " lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    int cyc;
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    start  = 1'b0;
    op     = 3'd0;
    rs_val = 32'd0;
    rt_val = 32'd0;

    vt[0]  = '{3'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vt[1]  = '{3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vt[2]  = '{3'd4, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'h7FFFFFFF, 10};
    vt[3]  = '{3'd5, 32'h12345678, 32'd0,        32'h12345678, 32'h7FFFFFFF, 0};
    vt[4]  = '{3'd6, 32'h9ABCDEF0, 32'd0,        32'h12345678, 32'h9ABCDEF0, 0};
    vt[5]  = '{3'd3, 32'd5,        32'd0,        32'h12345678, 32'h9ABCDEF0, 10};
    vt[6]  = '{3'd4, 32'd5,        32'd0,        32'h12345678, 32'h9ABCDEF0, 10};
    vt[7]  = '{3'd0, 32'd1,        32'd1,        32'h12345678, 32'h9ABCDEF0, 0};
    vt[8]  = '{3'd7, 32'd1,        32'd1,        32'h12345678, 32'h9ABCDEF0, 0};
    vt[9]  = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vt[10] = '{3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[11] = '{3'd2, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vt[12] = '{3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vt[13] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vt[14] = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};

    // Reset state, and pending tracking start even while held in reset.
    repeat (2) @(negedge clk);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    chk("reset pending idle", {63'd0, pending}, 64'd0);
    start = 1'b1;
    op    = 3'd3;
    #1;
    chk("reset pending start", {63'd0, pending}, 64'd1);
    @(negedge clk);
    chk("reset no accept", {63'd0, busy}, 64'd0);
    start = 1'b0;
    op    = 3'd0;
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].cyc, $sformatf("vec%0d", i));

    // Starts (arith and mthi) during a multu are ignored.
    start  = 1'b1;
    op     = 3'd2;
    rs_val = 32'hFFFFFFFF;
    rt_val = 32'd2;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    cyc   = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin
        start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd3;
        #1;
        chk("ign pending", {63'd0, pending}, 64'd1);
      end else if (cyc == 3) begin
        start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF;
      end else begin
        start = 1'b0; op = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    op    = 3'd0;
    chk("ign busy_cycles", 64'(cyc), 64'd5);
    chk("ign hi", {32'd0, hi}, 64'h1);
    chk("ign lo", {32'd0, lo}, 64'hFFFFFFFE);

    // Reset mid-operation aborts with no later completion update.
    start  = 1'b1;
    op     = 3'd1;
    rs_val = 32'd6;
    rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    op    = 3'd0;
    chk("abort busy1", {63'd0, busy}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort hi", {32'd0, hi}, 64'd0);
    chk("abort lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort later busy", {63'd0, busy}, 64'd0);
    chk("abort later lo", {32'd0, lo}, 64'd0);
    run_op(3'd1, 32'd6, 32'd7, 32'd0, 32'h2A, 5, "remult");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_busy_unit.md
Name: mdu_busy_unit

Overview:
- Multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult, multu, div and divu as multi-cycle operations.
- Produces the busy/pending indication that the stall controller consumes to freeze PC and D, and to clear E, for mfhi/mflo/mthi/mtlo/md instructions.
- It is the producing end of the stall interface: it signals the hazard; the stall controller only reacts to it.

Parameters:
- MULT_CYCLES, 5, number of cycles busy stays high for mult/multu; legal range 1..15.
- DIV_CYCLES, 10, number of cycles busy stays high for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request from E stage to begin or perform the operation in op.
- op  input  3  operation code: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- rs_val  input  32  forwarded rs operand; dividend / multiplicand / mthi-mtlo data.
- rt_val  input  32  forwarded rt operand; divisor / multiplier.
- busy  output  1  registered; high while an operation is in flight.
- pending  output  1  combinational: start & (op in 1..4), OR busy. The stall controller uses this signal.
- hi  output  32  current HI register value.
- lo  output  32  current LO register value.

Behaviour:
- Reset (asynchronous, immediate): busy=0, hi=0, lo=0, internal counter=0, latched results cleared. pending then equals start & (op in 1..4).
- Idle state: busy=0.
- Starting an arithmetic operation: on an edge with start=1 and op in 1..4:
  - latch the op and compute the 64-bit result from rs_val/rt_val at this edge;
  - load the counter with N (MULT_CYCLES or DIV_CYCLES);
  - busy=1 from this edge.
- Busy state:
  - the counter decrements every edge;
  - on the edge where the counter reaches 1: busy->0, and hi/lo update in that same edge.
  - busy is therefore high for exactly N cycles; new hi/lo are visible in the cycle after busy falls.
- Arithmetic rules:
  - mult: signed 32x32->64; hi=[63:32], lo=[31:0].
  - multu: the same, unsigned.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
- Divide by zero (rt_val=0 on div/divu): the op still runs its full DIV_CYCLES busy period; hi and lo are left unchanged at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. There is no trap.
- mthi/mtlo: when start=1 and busy=0, write rs_val to hi (or lo) at the next edge. busy stays 0, and pending does not rise for these ops.
- Start while busy (any op, including mthi/mtlo): ignored. No state change and no restart; the in-flight op completes normally. The stall controller must prevent this; the unit's ignore behaviour is mandatory regardless.
- op 0/7 with start=1: no effect.
- Reset asserted mid-operation: the operation is aborted, busy drops immediately, and hi/lo=0. No completion update occurs after reset deasserts.
- Reset deassertion: the first edge after deassertion may accept a start.
- Back-to-back operations: a start in the cycle immediately after busy falls is accepted.
- hi/lo outputs always reflect the registers. mfhi/mflo read them externally; the stall controller guarantees no read while pending=1.

Test Plan:
- Reset, then a single cycle of start=1, op=1 (mult), rs_val=0xFFFFFFFD (-3), rt_val=5.
  -> pending=1 in the start cycle; busy=1 for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- op=3 (div), rs_val=7, rt_val=0xFFFFFFFE (-2).
  -> busy for 10 cycles; then lo=0xFFFFFFFD, hi=0x00000001.
- op=4 (divu), rs_val=0xFFFFFFFF, rt_val=2.
  -> lo=0x7FFFFFFF, hi=0x00000001 after 10 cycles.
- Preload with op=5 (mthi) 0x12345678 and op=6 (mtlo) 0x9ABCDEF0, then div by rt_val=0.
  -> busy for 10 cycles; hi/lo stay 0x12345678/0x9ABCDEF0. Verify pending stays 0 during the mthi/mtlo cycles.
- During a multu (rs_val=0xFFFFFFFF, rt_val=2), assert start with op=1 and with op=5 at busy cycle 2.
  -> both ignored; the result is hi=0x00000001, lo=0xFFFFFFFE, and the busy length stays 5.
- Start mult 6*7, then assert reset at busy cycle 3.
  -> busy=0 and hi=lo=0 immediately; after release no update to 42 occurs. A new mult 6*7 then gives lo=0x0000002A, hi=0.
